// File: rtl/io_pkg.sv
// Shared types and constants for unidade_entrada_saida: input FSM states and
// the hex to active-low 7-segment table ({g..a}).
package io_pkg;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    ESPERA   = 2'd1,
    CONFIRMA = 2'd2,
    SOLTA    = 2'd3
  } estado_e;

  localparam logic [6:0] SEG_APAGADO = 7'h7F;

  function automatic logic [6:0] hex_para_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/debounce_botao.sv
// Confirm-button conditioning: 2-FF synchronizer, consecutive-sample debounce
// and a one-cycle pulse on each press (0->1 of the debounced level).
module debounce_botao #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic botao_raw,
  output logic pressionado,
  output logic borda
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pres_q, pres_d;
  logic             borda_q;
  logic             nivel_c;

  // button is active-low; the synchronizer resets to the released level
  assign nivel_c = ~sync_q[1];

  always_comb begin
    cnt_d  = '0;
    pres_d = pres_q;
    if (nivel_c != pres_q) begin
      if (cnt_q == CNT_MAX) begin
        pres_d = nivel_c;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      pres_q  <= 1'b0;
      borda_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], botao_raw};
      cnt_q   <= cnt_d;
      pres_q  <= pres_d;
      borda_q <= pres_d & ~pres_q;
    end
  end

  assign pressionado = pres_q;
  assign borda       = borda_q;

endmodule

// File: rtl/unidade_entrada_saida.sv
// I/O responder for the multicycle control unit: debounced IN handshake and
// hex 7-segment OUT display. Build option IO_SIGN_EXTEND_EN sign-extends the switch word.
module unidade_entrada_saida #(
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned SW_W            = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned DIGITS          = 4,
  parameter int unsigned SCAN_CYCLES     = 50000
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              botao_raw,
  input  logic [SW_W-1:0]   chaves,
  input  logic              sinalIn,
  input  logic              sinalOut,
  input  logic              sinalDisplay,
  input  logic [DATA_W-1:0] dadoSaida,
  output logic              confirmaEntrada,
  output logic [DATA_W-1:0] dadoEntrada,
  output logic              displayValido,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] anodo
);
  import io_pkg::*;

  localparam int unsigned SCAN_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int unsigned DIG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);
  localparam logic [DIG_W-1:0]  DIG_LAST  = DIG_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] ANODO_UM  = DIGITS'(1);

  logic              pressionado, borda;
  logic [SW_W-1:0]   chaves_m_q, chaves_s_q;
  logic [DATA_W-1:0] entrada_ext_c;
  estado_e           estado_q;
  logic              confirma_q;
  logic [DATA_W-1:0] dado_q;
  logic [DATA_W-1:0] display_q;
  logic              valido_q;
  logic [SCAN_W-1:0] scan_q;
  logic [DIG_W-1:0]  digito_q;
  logic [6:0]        seg_q;
  logic [DIGITS-1:0] anodo_q;
  logic [3:0]        nibble_c;

  debounce_botao #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clock      (clock),
    .reset_n    (reset_n),
    .botao_raw  (botao_raw),
    .pressionado(pressionado),
    .borda      (borda)
  );

`ifdef IO_SIGN_EXTEND_EN
  assign entrada_ext_c = DATA_W'($signed(chaves_s_q));
`else
  assign entrada_ext_c = DATA_W'(chaves_s_q);
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      chaves_m_q <= '0;
      chaves_s_q <= '0;
    end else begin
      chaves_m_q <= chaves;
      chaves_s_q <= chaves_m_q;
    end
  end

  // IN handshake: one press while a request is pending yields one capture and one pulse
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q   <= OCIOSO;
      confirma_q <= 1'b0;
      dado_q     <= '0;
    end else begin
      confirma_q <= 1'b0;
      case (estado_q)
        OCIOSO: begin
          if (sinalIn) estado_q <= ESPERA;
        end
        ESPERA: begin
          if (!sinalIn) begin
            estado_q <= OCIOSO;
          end else if (borda) begin
            estado_q   <= CONFIRMA;
            confirma_q <= 1'b1;
            dado_q     <= entrada_ext_c;
          end
        end
        CONFIRMA: estado_q <= SOLTA;
        SOLTA: begin
          if (!pressionado) estado_q <= OCIOSO;
        end
        default: estado_q <= OCIOSO;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      display_q <= '0;
      valido_q  <= 1'b0;
    end else if (sinalOut && sinalDisplay) begin
      display_q <= dadoSaida;
      valido_q  <= 1'b1;
    end
  end

  assign nibble_c = 4'(display_q >> {digito_q, 2'b00});

  // digit scan; seg and anodo are registered together from the current digit index
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scan_q   <= '0;
      digito_q <= '0;
      seg_q    <= SEG_APAGADO;
      anodo_q  <= ~ANODO_UM;
    end else begin
      if (scan_q == SCAN_LAST) begin
        scan_q   <= '0;
        digito_q <= (digito_q == DIG_LAST) ? '0 : digito_q + DIG_W'(1);
      end else begin
        scan_q <= scan_q + SCAN_W'(1);
      end
      seg_q   <= valido_q ? hex_para_seg(nibble_c) : SEG_APAGADO;
      anodo_q <= ~(ANODO_UM << digito_q);
    end
  end

  assign confirmaEntrada = confirma_q;
  assign dadoEntrada     = dado_q;
  assign displayValido   = valido_q;
  assign seg             = seg_q;
  assign anodo           = anodo_q;

endmodule

// File: tb/tb_unidade_entrada_saida.sv
// Randomized scoreboard bench for unidade_entrada_saida (IN handshake and display scan).
module tb_unidade_entrada_saida;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned SW_W   = 8;
  localparam int unsigned DEB    = 4;
  localparam int unsigned DIGITS = 4;
  localparam int unsigned SCAN   = 2;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              botao_raw = 1'b1;
  logic [SW_W-1:0]   chaves = '0;
  logic              sinalIn = 1'b0;
  logic              sinalOut = 1'b0;
  logic              sinalDisplay = 1'b0;
  logic [DATA_W-1:0] dadoSaida = '0;
  logic              confirmaEntrada;
  logic [DATA_W-1:0] dadoEntrada;
  logic              displayValido;
  logic [6:0]        seg;
  logic [DIGITS-1:0] anodo;

  int n_cmp = 0;
  int n_err = 0;

  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] ultimo_dado = '0;
  logic [DATA_W-1:0] exp_disp = '0;
  logic              exp_valid = 1'b0;
  logic              conf_prev = 1'b0;
  logic [6:0]        seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  unidade_entrada_saida #(
    .DATA_W(DATA_W), .SW_W(SW_W), .DEBOUNCE_CYCLES(DEB), .DIGITS(DIGITS), .SCAN_CYCLES(SCAN)
  ) dut (
    .clock(clock), .reset_n(reset_n), .botao_raw(botao_raw), .chaves(chaves),
    .sinalIn(sinalIn), .sinalOut(sinalOut), .sinalDisplay(sinalDisplay), .dadoSaida(dadoSaida),
    .confirmaEntrada(confirmaEntrada), .dadoEntrada(dadoEntrada), .displayValido(displayValido),
    .seg(seg), .anodo(anodo)
  );

  always #5 clock = ~clock;

  task automatic check(input string nome, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nome, got, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] estende(input logic [SW_W-1:0] sw);
    int v;
    v = int'(sw);
`ifdef IO_SIGN_EXTEND_EN
    if (sw[SW_W-1]) v = v - (1 << SW_W);
`endif
    return DATA_W'(v);
  endfunction

  // monitor: every acknowledge pops one expected word; the word must hold between acknowledges
  always @(negedge clock) begin
    if (reset_n) begin
      if (confirmaEntrada) begin
        check("pulso_largura", 32'(conf_prev), 32'(0));
        if (exp_q.size() == 0) begin
          check("pulso_inesperado", 32'(confirmaEntrada), 32'(0));
        end else begin
          ultimo_dado = exp_q.pop_front();
          check("dadoEntrada", 32'(dadoEntrada), 32'(ultimo_dado));
        end
      end else begin
        check("dado_retido", 32'(dadoEntrada), 32'(ultimo_dado));
      end
      conf_prev = confirmaEntrada;
    end else begin
      conf_prev = 1'b0;
    end
  end

  task automatic ciclos(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pressiona(input int n);
    botao_raw = 1'b0;
    ciclos(n);
    botao_raw = 1'b1;
  endtask

  task automatic strobe(input logic out, input logic [DATA_W-1:0] v);
    dadoSaida    = v;
    sinalOut     = out;
    sinalDisplay = 1'b1;
    ciclos(1);
    sinalOut     = 1'b0;
    sinalDisplay = 1'b0;
    dadoSaida    = DATA_W'($urandom);
    if (out) begin
      exp_disp  = v;
      exp_valid = 1'b1;
    end
  endtask

  // watch two full scan rounds: one digit at a time, SCAN cycles each, in order, showing its nibble
  task automatic check_scan();
    int prev;
    int run;
    int idx;
    logic primeira;
    logic [3:0] nib;
    prev = -1;
    run = 0;
    primeira = 1'b1;
    ciclos(2);
    check("displayValido", 32'(displayValido), 32'(exp_valid));
    repeat (2 * DIGITS * SCAN + 1) begin
      idx = -1;
      for (int i = 0; i < int'(DIGITS); i++) if (!anodo[i]) idx = i;
      check("anodo_um_ativo", 32'($countones(~anodo)), 32'(1));
      if (idx >= 0) begin
        nib = 4'(exp_disp >> (4 * idx));
        check("seg", 32'(seg), 32'(exp_valid ? seg_tab[nib] : 7'h7F));
        if (prev < 0) begin
          run = 1;
        end else if (idx == prev) begin
          run++;
          check("scan_permanencia", 32'(run <= int'(SCAN)), 32'(1));
        end else begin
          check("scan_proximo", 32'(idx), 32'((prev + 1) % int'(DIGITS)));
          if (!primeira) check("scan_duracao", 32'(run), 32'(SCAN));
          primeira = 1'b0;
          run = 1;
        end
        prev = idx;
      end
      ciclos(1);
    end
  endtask

  initial begin
    int k;
    int modo;
    logic [SW_W-1:0] sw;

    ciclos(2);
    check("reset_confirma", 32'(confirmaEntrada), 32'(0));
    check("reset_dado", 32'(dadoEntrada), 32'(0));
    check("reset_valido", 32'(displayValido), 32'(0));
    check("reset_seg", 32'(seg), 32'(7'h7F));
    check("reset_anodo", 32'(anodo), 32'(4'b1110));
    reset_n = 1'b1;
    ciclos(3);

    // directed handshake with latency measurement
    chaves  = 8'hA5;
    sinalIn = 1'b1;
    ciclos(3);
    exp_q.push_back(estende(8'hA5));
    botao_raw = 1'b0;
    k = 0;
    while (!confirmaEntrada && k < 30) begin
      ciclos(1);
      k++;
    end
    check("latencia_confirma", 32'(k), 32'(DEB + 3));
    ciclos(12 - ((k < 12) ? k : 12));
    botao_raw = 1'b1;
    sinalIn   = 1'b0;
    ciclos(DEB + 6);

    for (int it = 0; it < 40; it++) begin
      modo = int'($urandom_range(0, 3));
      sw   = SW_W'($urandom);
      case (modo)
        0: begin
          chaves  = sw;
          sinalIn = 1'b1;
          ciclos(3);
          exp_q.push_back(estende(sw));
          botao_raw = 1'b0;
          ciclos(2);
          if ($urandom_range(0, 1) == 1) strobe(1'b1, DATA_W'($urandom));
          else ciclos(1);
          ciclos(9);
          chaves    = SW_W'($urandom);
          botao_raw = 1'b1;
          sinalIn   = 1'b0;
          ciclos(DEB + 6);
        end
        1: begin
          chaves  = sw;
          sinalIn = 1'b1;
          ciclos(2);
          repeat (4) begin
            pressiona(int'($urandom_range(1, 3)));
            ciclos(int'($urandom_range(1, 3)));
          end
          sinalIn = 1'b0;
          ciclos(DEB + 6);
        end
        2: begin
          chaves  = sw;
          sinalIn = 1'b1;
          ciclos(int'($urandom_range(1, 4)));
          sinalIn = 1'b0;
          ciclos(2);
          pressiona(12);
          ciclos(DEB + 6);
        end
        default: begin
          botao_raw = 1'b0;
          ciclos(DEB + 6);
          chaves  = sw;
          sinalIn = 1'b1;
          ciclos(10);
          botao_raw = 1'b1;
          ciclos(DEB + 4);
          exp_q.push_back(estende(sw));
          pressiona(12);
          sinalIn = 1'b0;
          ciclos(DEB + 6);
        end
      endcase
      if (it % 8 == 7) check_scan();
    end

    // display path: ignored strobe without sinalOut, then directed 0x1234 and random values
    strobe(1'b0, DATA_W'($urandom));
    check_scan();
    strobe(1'b1, 16'h1234);
    check_scan();
    repeat (3) begin
      strobe(1'b1, DATA_W'($urandom));
      check_scan();
    end

    // reset asserted during the acknowledge cycle
    chaves  = SW_W'($urandom);
    sinalIn = 1'b1;
    ciclos(3);
    exp_q.push_back(estende(chaves));
    botao_raw = 1'b0;
    k = 0;
    while (!confirmaEntrada && k < 30) begin
      ciclos(1);
      k++;
    end
    check("confirma_antes_reset", 32'(confirmaEntrada), 32'(1));
    if (!confirmaEntrada && exp_q.size() > 0) void'(exp_q.pop_back());
    #1 reset_n = 1'b0;
    #1;
    check("reset_meio_confirma", 32'(confirmaEntrada), 32'(0));
    check("reset_meio_seg", 32'(seg), 32'(7'h7F));
    check("reset_meio_dado", 32'(dadoEntrada), 32'(0));
    check("reset_meio_valido", 32'(displayValido), 32'(0));
    check("reset_meio_anodo", 32'(anodo), 32'(4'b1110));
    ultimo_dado = '0;
    exp_disp    = '0;
    exp_valid   = 1'b0;
    ciclos(2);
    botao_raw = 1'b1;
    sinalIn   = 1'b0;
    reset_n   = 1'b1;
    ciclos(DEB + 6);
    check_scan();

    ciclos(5);
    check("fila_vazia", 32'(exp_q.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/unidade_entrada_saida.md
# unidade_entrada_saida

I/O responder that sits beside the multicycle control unit and answers its IN and OUT requests.
- IN: debounces the confirm push-button, captures the switch word, and returns a one-cycle `confirmaEntrada` pulse with `dadoEntrada` held stable for the register-bank write.
- OUT: latches the register value presented on `dadoSaida` and shows it in hex on a multiplexed 7-segment display.

## Interface
- `DATA_W`, 32: datapath word width.
- `SW_W`, 16: switch count; must be ≤ DATA_W.
- `DEBOUNCE_CYCLES`, 500000: consecutive equal samples needed to accept a button level change (10 ms at 50 MHz).
- `DIGITS`, 4: number of multiplexed 7-segment digits.
- `SCAN_CYCLES`, 50000: clocks each digit stays enabled.

Ports:
- `clock`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `botao_raw`  in  1  raw confirm button, active-low (0 = pressed), asynchronous.
- `chaves`  in  SW_W  raw switches, asynchronous.
- `sinalIn`  in  1  IN request from the control unit, held until confirmed.
- `sinalOut`  in  1  OUT instruction in progress.
- `sinalDisplay`  in  1  display-latch strobe.
- `dadoSaida`  in  DATA_W  value to display.
- `confirmaEntrada`  out  1  one-cycle IN acknowledge.
- `dadoEntrada`  out  DATA_W  captured input word.
- `displayValido`  out  1  display holds a latched value.
- `seg`  out  7  segments {g..a}, active-low.
- `anodo`  out  DIGITS  digit enables, active-low, one-hot-zero.

## Operation
- **Synchronizers.** `botao_raw` and `chaves` each pass through a 2-FF synchronizer.
- **Debounce.** The synchronized button level must differ from the current debounced level for DEBOUNCE_CYCLES consecutive cycles before `pressionado` (debounced, active-high) toggles. Any sample equal to the current debounced level clears the counter.
- **Edge detect.** `borda` = 1 for one cycle on each 0→1 of `pressionado`.
- **Input FSM states:** OCIOSO, ESPERA, CONFIRMA, SOLTA.
  - OCIOSO → ESPERA when `sinalIn`=1.
  - ESPERA → CONFIRMA on `borda`. In the same edge, `dadoEntrada` ← extended synchronized `chaves`.
  - ESPERA → OCIOSO if `sinalIn`=0; the request was withdrawn and no pulse is issued.
  - CONFIRMA: `confirmaEntrada`=1 for exactly this cycle; then → SOLTA unconditionally.
  - SOLTA → OCIOSO when `pressionado`=0, so one press yields one input.
  - A press already held when `sinalIn` rises produces no `borda`. A release and re-press is required.
- **`dadoEntrada` hold.** Held until the next capture and never changes while the FSM is outside CONFIRMA.
- **Output latch.** When `sinalOut`=1 and `sinalDisplay`=1 on an edge: `display` ← `dadoSaida` and `displayValido` ← 1. Otherwise both hold.
- **Scan.**
  - The scan counter wraps at SCAN_CYCLES−1 and then advances the digit index, which wraps DIGITS−1→0.
  - Digit i shows nibble `display[4i+3:4i]` in hex (0–9, A–F standard patterns).
  - `seg`=7'h7F (blank) while `displayValido`=0.

## Timing
- **Reset values:** FSM=OCIOSO; `confirmaEntrada`=0; `dadoEntrada`=0; `display`=0; `displayValido`=0; `seg`=7'h7F; `anodo`=~1 (digit 0); debounce counter=0; `pressionado`=0; scan counter and digit index=0.
- **Reset mid-operation:** the pulse is aborted, the FSM returns to OCIOSO, and the display is blanked.
- **Press latency:** a stable press beginning at cycle t raises `pressionado` at t+2+DEBOUNCE_CYCLES. `confirmaEntrada` is high in the following cycle.
- **Pulse width:** `confirmaEntrada` is never high more than one cycle per request.
- **Output latch latency:** `displayValido` and `display` update one edge after the strobe. `seg`/`anodo` reflect the new value on the next edge.
- **Outputs are registered:** `seg` and `anodo` are registered and change together.
- **Simultaneous events:** IN and OUT paths are independent. A strobe during an IN wait is honoured.

## Configuration
- Macro `IO_SIGN_EXTEND_EN`:
  - Defined: `dadoEntrada` = `chaves` sign-extended from bit SW_W−1.
  - Undefined: zero-extended.

## Structure
- Package `io_pkg` holds:
  - the FSM state enum;
  - the hex→7-segment constant table/function;
  - blank code 7'h7F.
- Sub-module `debounce_botao` contains the synchronizer, counter, level register and edge pulse. Its outputs are `pressionado` and `borda`.

## Test plan
Bench parameters: DATA_W=16, SW_W=8, DEBOUNCE_CYCLES=4, SCAN_CYCLES=2, DIGITS=4.
- **IN handshake.** `sinalIn`=1, `chaves`=8'hA5, `botao_raw`=0 for 12 cycles → exactly one `confirmaEntrada` pulse; `dadoEntrada`=16'h00A5 (16'hFFA5 with `IO_SIGN_EXTEND_EN`).
- **Bounce.** Press glitches of 2–3 cycles, repeated → no pulse; `dadoEntrada` unchanged.
- **Press held before request.** Button held, then `sinalIn` rises → no pulse. Release ≥6 cycles, press again → one pulse.
- **Request withdrawn.** `sinalIn` drops while in ESPERA → FSM back to OCIOSO; a later press gives no pulse.
- **OUT/display.** `dadoSaida`=16'h1234, `sinalOut`=`sinalDisplay`=1 for one cycle → `displayValido`=1. Scan shows the patterns for 4, 3, 2, 1 on `anodo` ~0001, ~0010, ~0100, ~1000, two cycles each, then wraps.
- **Reset mid-pulse.** Assert `reset_n`=0 in the CONFIRMA cycle → `confirmaEntrada`=0 immediately; `seg`=7'h7F; `dadoEntrada`=0.
